// File: rtl/vend_pkg.sv
// Shared types and constants for the vending sale controller and its change dispenser.
package vend_pkg;

    localparam int unsigned CREDIT_W_DEFAULT = 19;
    localparam int unsigned COIN_1000        = 1000;
    localparam int unsigned COIN_2000        = 2000;
    localparam int unsigned COIN_5000        = 5000;
    localparam int unsigned COIN_SUM_W       = 14;   // holds 8000, the largest single-cycle deposit

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_COLLECT,
        ST_VEND,
        ST_CHANGE
    } state_t;

    function automatic logic [COIN_SUM_W-1:0] coin_sum(input logic p1, input logic p2, input logic p5);
        return (p1 ? COIN_SUM_W'(COIN_1000) : '0)
             + (p2 ? COIN_SUM_W'(COIN_2000) : '0)
             + (p5 ? COIN_SUM_W'(COIN_5000) : '0);
    endfunction

endpackage

// File: rtl/vend_change_dispenser.sv
// Greedy change payer: one coin strobe per cycle, largest coin first, then latches the
// sub-1000 remainder as residual. done is high in the cycle the remainder is settled.
module vend_change_dispenser
    import vend_pkg::*;
#(
    parameter int unsigned CREDIT_W = CREDIT_W_DEFAULT
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                load,
    input  logic                clear,
    input  logic [CREDIT_W-1:0] amount,
    output logic                chg1000,
    output logic                chg2000,
    output logic                chg5000,
    output logic                done,
    output logic [9:0]          residual
);

    logic [CREDIT_W-1:0] rem;
    logic                active;

    // Combinational so the controller can leave CHANGE on the same edge the remainder settles.
    assign done = active && (rem < CREDIT_W'(COIN_1000));

    // NOTE: state and strobes use non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clock) begin
        if (reset) begin
            rem      <= '0;
            active   <= 1'b0;
            chg1000  <= 1'b0;
            chg2000  <= 1'b0;
            chg5000  <= 1'b0;
            residual <= '0;
        end else begin
            chg1000 <= 1'b0;
            chg2000 <= 1'b0;
            chg5000 <= 1'b0;
            if (load) begin
                rem    <= amount;
                active <= 1'b1;
            end else if (active) begin
                if (rem >= CREDIT_W'(COIN_5000)) begin
                    chg5000 <= 1'b1;
                    rem     <= rem - CREDIT_W'(COIN_5000);
                end else if (rem >= CREDIT_W'(COIN_2000)) begin
                    chg2000 <= 1'b1;
                    rem     <= rem - CREDIT_W'(COIN_2000);
                end else if (rem >= CREDIT_W'(COIN_1000)) begin
                    chg1000 <= 1'b1;
                    rem     <= rem - CREDIT_W'(COIN_1000);
                end else begin
                    residual <= rem[9:0];
                    active   <= 1'b0;
                end
            end
            if (clear) begin
                residual <= '0;
            end
        end
    end

endmodule

// File: rtl/vend_sale_controller.sv
// Vending sale sequencer: price latch, coin credit with overflow rejection, dispense handshake, change.
// Optional COLLECT inactivity refund is enabled by defining VEND_TIMEOUT_EN.
module vend_sale_controller
    import vend_pkg::*;
#(
    parameter int unsigned CREDIT_W       = CREDIT_W_DEFAULT,
    parameter int unsigned TIMEOUT_CYCLES = 100000
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                sel_valid,
    input  logic [CREDIT_W-1:0] sel_price,
    input  logic                pulse1000,
    input  logic                pulse2000,
    input  logic                pulse5000,
    input  logic                cancel,
    input  logic                dispense_ready,
    output logic                busy,
    output logic                dispense_valid,
    output logic [CREDIT_W-1:0] credit,
    output logic                chg1000,
    output logic                chg2000,
    output logic                chg5000,
    output logic [9:0]          residual,
    output logic                coin_reject,
    output logic                sel_error,
    output logic                timeout
);

    state_t                  state;
    logic [CREDIT_W-1:0]     price;
    logic                    coin_any;
    logic [COIN_SUM_W-1:0]   coin_total;
    logic [CREDIT_W:0]       credit_sum;
    logic                    overflow;
    logic                    coin_ok;
    logic [CREDIT_W-1:0]     credit_after_coin;
    logic [CREDIT_W-1:0]     change_amount;
    logic                    paid;
    logic                    timeout_hit;
    logic                    disp_load;
    logic                    disp_clear;
    logic                    disp_done;
    logic [CREDIT_W-1:0]     disp_amount;

    assign coin_any          = pulse1000 | pulse2000 | pulse5000;
    assign coin_total        = coin_sum(pulse1000, pulse2000, pulse5000);
    assign credit_sum        = {1'b0, credit} + (CREDIT_W+1)'(coin_total);
    assign overflow          = credit_sum[CREDIT_W];
    assign coin_ok           = (state == ST_COLLECT) && coin_any && !overflow;
    assign credit_after_coin = coin_ok ? credit_sum[CREDIT_W-1:0] : credit;
    assign paid              = credit >= price;
    assign change_amount     = credit - price;
    assign disp_clear        = (state == ST_IDLE) && sel_valid && (sel_price != '0);

`ifdef VEND_TIMEOUT_EN
    localparam int unsigned TO_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [TO_W-1:0] idle_cnt;

    assign timeout_hit = (state == ST_COLLECT) && !coin_ok && (idle_cnt == TO_W'(TIMEOUT_CYCLES - 1));

    // Counts COLLECT cycles since entry or the last accepted coin.
    always_ff @(posedge clock) begin
        if (reset || (state != ST_COLLECT) || coin_ok) begin
            idle_cnt <= '0;
        end else begin
            idle_cnt <= idle_cnt + TO_W'(1);
        end
    end
`else
    logic unused_timeout_cfg;
    assign unused_timeout_cfg = (TIMEOUT_CYCLES == 0);
    assign timeout_hit        = 1'b0;
`endif

    // NOTE: every signal written here gets a default first, so no path can infer a latch.
    always_comb begin
        disp_load   = 1'b0;
        disp_amount = '0;
        case (state)
            ST_COLLECT: begin
                if (!paid && (cancel || timeout_hit)) begin
                    disp_load   = 1'b1;
                    disp_amount = credit_after_coin;
                end
            end
            ST_VEND: begin
                if (dispense_ready && (change_amount != '0)) begin
                    disp_load   = 1'b1;
                    disp_amount = change_amount;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state          <= ST_IDLE;
            price          <= '0;
            credit         <= '0;
            busy           <= 1'b0;
            dispense_valid <= 1'b0;
            coin_reject    <= 1'b0;
            sel_error      <= 1'b0;
            timeout        <= 1'b0;
        end else begin
            coin_reject <= 1'b0;
            sel_error   <= 1'b0;
            timeout     <= 1'b0;
            case (state)
                ST_IDLE: begin
                    coin_reject <= coin_any;
                    if (sel_valid) begin
                        if (sel_price != '0) begin
                            price  <= sel_price;
                            credit <= '0;
                            busy   <= 1'b1;
                            state  <= ST_COLLECT;
                        end else begin
                            sel_error <= 1'b1;
                        end
                    end
                end
                ST_COLLECT: begin
                    coin_reject <= coin_any && overflow;
                    credit      <= credit_after_coin;
                    // Payment already covered wins over cancel and timeout in the same cycle.
                    if (paid) begin
                        dispense_valid <= 1'b1;
                        state          <= ST_VEND;
                    end else if (cancel || timeout_hit) begin
                        timeout <= timeout_hit && !cancel;
                        credit  <= '0;
                        state   <= ST_CHANGE;
                    end
                end
                ST_VEND: begin
                    coin_reject <= coin_any;
                    if (dispense_ready) begin
                        dispense_valid <= 1'b0;
                        credit         <= '0;
                        if (change_amount == '0) begin
                            busy  <= 1'b0;
                            state <= ST_IDLE;
                        end else begin
                            state <= ST_CHANGE;
                        end
                    end
                end
                ST_CHANGE: begin
                    coin_reject <= coin_any;
                    if (disp_done) begin
                        busy  <= 1'b0;
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    vend_change_dispenser #(
        .CREDIT_W (CREDIT_W)
    ) u_change (
        .clock    (clock),
        .reset    (reset),
        .load     (disp_load),
        .clear    (disp_clear),
        .amount   (disp_amount),
        .chg1000  (chg1000),
        .chg2000  (chg2000),
        .chg5000  (chg5000),
        .done     (disp_done),
        .residual (residual)
    );

endmodule

// File: tb/tb_vend_sale_controller.sv
// Self-checking bench for vend_sale_controller: directed sales plus randomized sales scored
// against an arithmetic sale model (credit sums, greedy change by division).
module tb_vend_sale_controller;

    localparam int CW         = 19;
    localparam int CREDIT_MAX = (1 << CW) - 1;

    logic          clock = 1'b0;
    logic          reset;
    logic          sel_valid;
    logic [CW-1:0] sel_price;
    logic          pulse1000, pulse2000, pulse5000;
    logic          cancel;
    logic          dispense_ready;
    logic          busy;
    logic          dispense_valid;
    logic [CW-1:0] credit;
    logic          chg1000, chg2000, chg5000;
    logic [9:0]    residual;
    logic          coin_reject;
    logic          sel_error;
    logic          timeout;

    int checks       = 0;
    int failures     = 0;
    int model_credit = 0;
    int model_price  = 0;

    always #5 clock = ~clock;

    vend_sale_controller #(
        .CREDIT_W       (CW),
        .TIMEOUT_CYCLES (16)
    ) dut (
        .clock          (clock),
        .reset          (reset),
        .sel_valid      (sel_valid),
        .sel_price      (sel_price),
        .pulse1000      (pulse1000),
        .pulse2000      (pulse2000),
        .pulse5000      (pulse5000),
        .cancel         (cancel),
        .dispense_ready (dispense_ready),
        .busy           (busy),
        .dispense_valid (dispense_valid),
        .credit         (credit),
        .chg1000        (chg1000),
        .chg2000        (chg2000),
        .chg5000        (chg5000),
        .residual       (residual),
        .coin_reject    (coin_reject),
        .sel_error      (sel_error),
        .timeout        (timeout)
    );

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    task automatic start_sale(input int price);
        sel_valid = 1'b1;
        sel_price = CW'(price);
        step();
        sel_valid = 1'b0;
        model_price  = price;
        model_credit = 0;
        check("start_busy", busy, 1);
        check("start_credit", credit, 0);
        check("start_residual", residual, 0);
    endtask

    // One COLLECT cycle with the given coins; the model adds them unless the total would overflow.
    task automatic coin(input logic a, input logic b, input logic c, input logic with_cancel);
        int   sum;
        logic exp_rej;
        sum = (a ? 1000 : 0) + (b ? 2000 : 0) + (c ? 5000 : 0);
        pulse1000 = a;
        pulse2000 = b;
        pulse5000 = c;
        cancel    = with_cancel;
        step();
        pulse1000 = 1'b0;
        pulse2000 = 1'b0;
        pulse5000 = 1'b0;
        cancel    = 1'b0;
        if (model_credit + sum > CREDIT_MAX) begin
            exp_rej = 1'b1;
        end else begin
            exp_rej = 1'b0;
            model_credit += sum;
        end
        check("coin_reject", coin_reject, exp_rej);
        check("coin_credit", credit, with_cancel ? 0 : model_credit);
    endtask

    // Observes the change phase until busy drops and compares against greedy division.
    task automatic collect_change(input int amount);
        int exp_q[$];
        int got_q[$];
        int r;
        int cyc;
        r = amount;
        repeat (r / 5000) exp_q.push_back(5000);
        r = r % 5000;
        repeat (r / 2000) exp_q.push_back(2000);
        r = r % 2000;
        repeat (r / 1000) exp_q.push_back(1000);
        r = r % 1000;
        cyc = 0;
        while (busy === 1'b1 && cyc < 200) begin
            step();
            cyc++;
            check("change_onehot0", ($countones({chg1000, chg2000, chg5000}) <= 1) ? 1 : 0, 1);
            check("change_no_dispense", dispense_valid, 0);
            if (chg5000) got_q.push_back(5000);
            else if (chg2000) got_q.push_back(2000);
            else if (chg1000) got_q.push_back(1000);
        end
        check("change_done", busy, 0);
        check("change_count", got_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            check("change_coin", got_q[i], exp_q[i]);
        end
        check("change_residual", residual, r);
        check("change_credit", credit, 0);
    endtask

    // Expects dispense_valid now; holds ready low for delay cycles, optionally probing a VEND coin.
    task automatic vend_handshake(input int delay, input bit probe);
        int change;
        check("vend_valid", dispense_valid, 1);
        for (int i = 0; i < delay; i++) begin
            if (probe && i == 0) begin
                pulse5000 = 1'b1;
                step();
                pulse5000 = 1'b0;
                check("vend_coin_reject", coin_reject, 1);
            end else begin
                step();
            end
            check("vend_hold_valid", dispense_valid, 1);
            check("vend_hold_credit", credit, model_credit);
        end
        dispense_ready = 1'b1;
        step();
        dispense_ready = 1'b0;
        change = model_credit - model_price;
        check("vend_valid_drop", dispense_valid, 0);
        check("vend_credit_clear", credit, 0);
        check("vend_busy", busy, (change != 0) ? 1 : 0);
        collect_change(change);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired observed=running expected=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [2:0] c;
        bit         do_cancel;
        int         ncoin;
        int         n;

        reset          = 1'b1;
        sel_valid      = 1'b0;
        sel_price      = '0;
        pulse1000      = 1'b0;
        pulse2000      = 1'b0;
        pulse5000      = 1'b0;
        cancel         = 1'b0;
        dispense_ready = 1'b0;
        repeat (2) step();
        reset = 1'b0;
        step();
        check("rst_busy", busy, 0);
        check("rst_dispense_valid", dispense_valid, 0);
        check("rst_credit", credit, 0);
        check("rst_strobes", {chg1000, chg2000, chg5000}, 0);
        check("rst_residual", residual, 0);
        check("rst_pulses", {coin_reject, sel_error, timeout}, 0);

        // price 3000, 1000 then 2000; a selection during COLLECT must be ignored
        start_sale(3000);
        sel_valid = 1'b1;
        sel_price = CW'(1000);
        coin(1'b1, 1'b0, 1'b0, 1'b0);
        sel_valid = 1'b0;
        coin(1'b0, 1'b1, 1'b0, 1'b0);
        check("d1_not_yet_valid", dispense_valid, 0);
        step();
        vend_handshake(0, 1'b0);

        // price 4000, two 5000 coins (second lands in the paid cycle) -> change 6000
        start_sale(4000);
        coin(1'b0, 1'b0, 1'b1, 1'b0);
        coin(1'b0, 1'b0, 1'b1, 1'b0);
        vend_handshake(2, 1'b1);

        // price 1500, 2000 -> change 500 left as residual
        start_sale(1500);
        coin(1'b0, 1'b1, 1'b0, 1'b0);
        step();
        vend_handshake(1, 1'b0);

        // price 9000, 2000 then cancel -> refund one 2000, residual cleared by the new sale
        start_sale(9000);
        coin(1'b0, 1'b1, 1'b0, 1'b0);
        coin(1'b0, 1'b0, 1'b0, 1'b1);
        check("d4_no_dispense", dispense_valid, 0);
        collect_change(model_credit);

        // coin in IDLE rejected; zero price refused
        pulse1000 = 1'b1;
        step();
        pulse1000 = 1'b0;
        check("idle_coin_reject", coin_reject, 1);
        check("idle_credit", credit, 0);
        step();
        check("idle_reject_pulse", coin_reject, 0);
        sel_valid = 1'b1;
        sel_price = '0;
        step();
        sel_valid = 1'b0;
        check("sel_error", sel_error, 1);
        check("sel_error_idle", busy, 0);
        step();
        check("sel_error_pulse", sel_error, 0);

        // overflow boundary: credit saturates against 2^CW-1, whole-cycle rejection
        start_sale(CREDIT_MAX);
        repeat (65) coin(1'b1, 1'b1, 1'b1, 1'b0);
        coin(1'b1, 1'b1, 1'b1, 1'b0);
        coin(1'b0, 1'b0, 1'b1, 1'b0);
        repeat (4) coin(1'b1, 1'b0, 1'b0, 1'b0);
        coin(1'b1, 1'b0, 1'b0, 1'b0);
        coin(1'b0, 1'b0, 1'b0, 1'b1);
        collect_change(model_credit);

        // reset mid-sale discards credit
        start_sale(9000);
        coin(1'b0, 1'b0, 1'b1, 1'b0);
        reset = 1'b1;
        step();
        reset = 1'b0;
        check("midrst_busy", busy, 0);
        check("midrst_credit", credit, 0);

`ifdef VEND_TIMEOUT_EN
        start_sale(5000);
        coin(1'b1, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 15; i++) begin
            step();
            check("to_wait", timeout, 0);
        end
        step();
        check("to_pulse", timeout, 1);
        check("to_busy", busy, 1);
        collect_change(1000);
`else
        start_sale(5000);
        coin(1'b1, 1'b0, 1'b0, 1'b0);
        repeat (20) step();
        check("no_to_pulse", timeout, 0);
        check("no_to_busy", busy, 1);
        coin(1'b0, 1'b0, 1'b0, 1'b1);
        collect_change(1000);
`endif

        // randomized sales
        for (int s = 0; s < 30; s++) begin
            do_cancel = ($urandom_range(0, 3) == 0);
            ncoin     = $urandom_range(0, 3);
            n         = 0;
            start_sale($urandom_range(1, 20000));
            while (model_credit < model_price && !(do_cancel && n >= ncoin)) begin
                repeat ($urandom_range(0, 2)) begin
                    step();
                    check("rnd_gap_credit", credit, model_credit);
                    check("rnd_gap_reject", coin_reject, 0);
                end
                c = 3'($urandom_range(1, 7));
                coin(c[0], c[1], c[2], 1'b0);
                n++;
            end
            if (model_credit < model_price) begin
                c = 3'($urandom_range(0, 7));
                coin(c[0], c[1], c[2], 1'b1);
                check("rnd_cancel_no_dispense", dispense_valid, 0);
                collect_change(model_credit);
            end else begin
                if ($urandom_range(0, 1) == 1) begin
                    c = 3'($urandom_range(1, 7));
                    coin(c[0], c[1], c[2], 1'b0);
                end else begin
                    step();
                end
                vend_handshake($urandom_range(0, 3), $urandom_range(0, 1) == 1);
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
